// File: rtl/axi_packet_pkg.sv
// Shared types and constants for the axi_packet memory target.
// Response codes, FSM state enums and the burst legality check.
package axi_packet_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int unsigned BOUNDARY = 4096;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // A burst is illegal if its byte span leaves the 4 KB page or its words run past memory.
    function automatic logic burst_err(input logic [31:0] addr, input logic [7:0] len,
                                       input logic [2:0] size, input int unsigned depth);
        int unsigned beats;
        beats = 32'(len) + 32'd1;
        return ((addr % BOUNDARY) + (beats << size) > BOUNDARY) || ((addr >> 2) + beats > depth);
    endfunction

endpackage

// File: rtl/axi_packet_if.sv
// AXI4 bus bundle between an initiator (master) and the axi_packet memory target (slave).
interface axi_packet_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
);
    logic [ADDR_WIDTH-1:0] AWADDR;
    logic [7:0]            AWLEN;
    logic [2:0]            AWSIZE;
    logic                  AWVALID;
    logic                  AWREADY;
    logic [DATA_WIDTH-1:0] WDATA;
    logic                  WVALID;
    logic                  WLAST;
    logic                  WREADY;
    logic [1:0]            BRESP;
    logic                  BVALID;
    logic                  BREADY;
    logic [ADDR_WIDTH-1:0] ARADDR;
    logic [7:0]            ARLEN;
    logic [2:0]            ARSIZE;
    logic                  ARVALID;
    logic                  ARREADY;
    logic [DATA_WIDTH-1:0] RDATA;
    logic [1:0]            RRESP;
    logic                  RLAST;
    logic                  RVALID;
    logic                  RREADY;

    modport master (
        output AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WVALID, WLAST, BREADY,
        output ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
        input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
    );

    modport slave (
        input  AWADDR, AWLEN, AWSIZE, AWVALID, WDATA, WVALID, WLAST, BREADY,
        input  ARADDR, ARLEN, ARSIZE, ARVALID, RREADY,
        output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RLAST, RVALID
    );

endinterface

// File: rtl/axi_packet_mem.sv
// Word memory with one synchronous write port and one asynchronous read port.
// Words are stored XOR'd with their index so zeroed power-up storage reads back word i = i.
module axi_packet_mem #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024,
    localparam int unsigned AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i ^ DATA_WIDTH'(waddr_i);
        end
    end

    assign rdata_o = mem_q[raddr_i] ^ DATA_WIDTH'(raddr_i);

endmodule

// File: rtl/axi_packet.sv
// AXI4 slave backed by on-chip word memory; independent write (AW/W/B) and read (AR/R) FSMs.
// Illegal bursts are still handshaked in full but answer SLVERR and never touch memory.
module axi_packet
    import axi_packet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned MEMORY_DEPTH = 1024
) (
    input logic         ACLK,
    input logic         ARESETn,
    axi_packet_if.slave bus
);

    localparam int unsigned MemAw = $clog2(MEMORY_DEPTH);

    w_state_e              w_state_q, w_state_d;
    logic [ADDR_WIDTH-1:0] widx_q, widx_d;
    logic [7:0]            wlen_q, wlen_d;
    logic [7:0]            wbeat_q, wbeat_d;
    logic                  werr_q, werr_d;

    r_state_e              r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0] ridx_q, ridx_d;
    logic [7:0]            rlen_q, rlen_d;
    logic [7:0]            rbeat_q, rbeat_d;
    logic                  rerr_q, rerr_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rlast_q, rlast_d;

    // Holds the ready outputs low while reset is asserted and for the first cycle after.
    logic                  live_q;

    logic                  aw_hs, w_hs, ar_hs, r_hs;
    logic                  mem_we;
    logic [MemAw-1:0]      mem_waddr, mem_raddr;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  unused_wlast;

    assign unused_wlast = bus.WLAST;

    assign aw_hs = bus.AWVALID && live_q && (w_state_q == W_IDLE);
    assign w_hs  = bus.WVALID && (w_state_q == W_DATA);
    assign ar_hs = bus.ARVALID && live_q && (r_state_q == R_IDLE);
    assign r_hs  = bus.RREADY && (r_state_q == R_DATA);

    assign mem_we    = w_hs && !werr_q;
    assign mem_waddr = MemAw'(32'(widx_q) + 32'(wbeat_q));
    // Idle: fetch beat 0 of the incoming request; busy: prefetch the beat after the current one.
    assign mem_raddr = (r_state_q == R_IDLE) ? MemAw'(bus.ARADDR >> 2)
                                             : MemAw'(32'(ridx_q) + 32'(rbeat_q) + 32'd1);

    axi_packet_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (MEMORY_DEPTH)
    ) u_mem (
        .clk_i   (ACLK),
        .we_i    (mem_we),
        .waddr_i (mem_waddr),
        .wdata_i (bus.WDATA),
        .raddr_i (mem_raddr),
        .rdata_o (mem_rdata)
    );

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            live_q    <= 1'b0;
            w_state_q <= W_IDLE;
            widx_q    <= '0;
            wlen_q    <= '0;
            wbeat_q   <= '0;
            werr_q    <= 1'b0;
            r_state_q <= R_IDLE;
            ridx_q    <= '0;
            rlen_q    <= '0;
            rbeat_q   <= '0;
            rerr_q    <= 1'b0;
            rdata_q   <= '0;
            rlast_q   <= 1'b0;
        end else begin
            live_q    <= 1'b1;
            w_state_q <= w_state_d;
            widx_q    <= widx_d;
            wlen_q    <= wlen_d;
            wbeat_q   <= wbeat_d;
            werr_q    <= werr_d;
            r_state_q <= r_state_d;
            ridx_q    <= ridx_d;
            rlen_q    <= rlen_d;
            rbeat_q   <= rbeat_d;
            rerr_q    <= rerr_d;
            rdata_q   <= rdata_d;
            rlast_q   <= rlast_d;
        end
    end

    always_comb begin
        w_state_d = w_state_q;
        widx_d    = widx_q;
        wlen_d    = wlen_q;
        wbeat_d   = wbeat_q;
        werr_d    = werr_q;
        unique case (w_state_q)
            W_IDLE: begin
                if (aw_hs) begin
                    widx_d    = bus.AWADDR >> 2;
                    wlen_d    = bus.AWLEN;
                    wbeat_d   = '0;
                    werr_d    = burst_err(32'(bus.AWADDR), bus.AWLEN, bus.AWSIZE, MEMORY_DEPTH);
                    w_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (w_hs) begin
                    if (wbeat_q == wlen_q) w_state_d = W_RESP;
                    else                   wbeat_d   = wbeat_q + 8'd1;
                end
            end
            W_RESP: begin
                if (bus.BREADY) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase

        r_state_d = r_state_q;
        ridx_d    = ridx_q;
        rlen_d    = rlen_q;
        rbeat_d   = rbeat_q;
        rerr_d    = rerr_q;
        rdata_d   = rdata_q;
        rlast_d   = rlast_q;
        unique case (r_state_q)
            R_IDLE: begin
                if (ar_hs) begin
                    ridx_d    = bus.ARADDR >> 2;
                    rlen_d    = bus.ARLEN;
                    rbeat_d   = '0;
                    rerr_d    = burst_err(32'(bus.ARADDR), bus.ARLEN, bus.ARSIZE, MEMORY_DEPTH);
                    rdata_d   = rerr_d ? '0 : mem_rdata;
                    rlast_d   = (bus.ARLEN == 8'd0);
                    r_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    if (rbeat_q == rlen_q) begin
                        rdata_d   = '0;
                        rlast_d   = 1'b0;
                        r_state_d = R_IDLE;
                    end else begin
                        rbeat_d = rbeat_q + 8'd1;
                        rdata_d = rerr_q ? '0 : mem_rdata;
                        rlast_d = ((rbeat_q + 8'd1) == rlen_q);
                    end
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_comb begin
        bus.AWREADY = live_q && (w_state_q == W_IDLE);
        bus.WREADY  = (w_state_q == W_DATA);
        bus.BVALID  = (w_state_q == W_RESP);
        bus.BRESP   = ((w_state_q == W_RESP) && werr_q) ? RESP_SLVERR : RESP_OKAY;
        bus.ARREADY = live_q && (r_state_q == R_IDLE);
        bus.RVALID  = (r_state_q == R_DATA);
        bus.RRESP   = ((r_state_q == R_DATA) && rerr_q) ? RESP_SLVERR : RESP_OKAY;
        bus.RDATA   = rdata_q;
        bus.RLAST   = rlast_q;
    end

endmodule

// File: tb/tb_axi_packet.sv
// Self-checking bench for axi_packet: directed vector table, random bursts against a
// word-array reference model, plus backpressure, concurrency and mid-burst reset sequences.
module tb_axi_packet;
    import axi_packet_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    axi_packet_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

    axi_packet #(
        .DATA_WIDTH   (32),
        .ADDR_WIDTH   (16),
        .MEMORY_DEPTH (1024)
    ) dut (
        .ACLK    (clk),
        .ARESETn (rst_n),
        .bus     (bus)
    );

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] model_mem [1024];
    logic [31:0] wq [$];

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  resp;
    } vec_t;

    vec_t vecs [21];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit model_err(input int unsigned a, input int unsigned len,
                                     input int unsigned sz);
        int unsigned beats;
        beats = len + 1;
        return ((a % 4096) + beats * (1 << sz) > 4096) || ((a / 4) + beats > 1024);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz,
                            input int bdelay, input logic [1:0] exp);
        int unsigned idx;
        int          cyc;
        logic [31:0] d;
        idx = 32'(a) / 4;
        bus.AWADDR  = a;
        bus.AWLEN   = len;
        bus.AWSIZE  = sz;
        bus.AWVALID = 1'b1;
        cyc = 0;
        while (bus.AWREADY !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        if (bus.AWREADY !== 1'b1) begin
            check("aw_timeout", 32'd0, 32'd1);
            bus.AWVALID = 1'b0;
            return;
        end
        tick();
        bus.AWVALID = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            d = (wq.size() > 0) ? wq.pop_front() : $urandom;
            bus.WDATA  = d;
            bus.WVALID = 1'b1;
            bus.WLAST  = (k == int'(len));
            cyc = 0;
            while (bus.WREADY !== 1'b1 && cyc < 100) begin tick(); cyc++; end
            if (bus.WREADY !== 1'b1) begin
                check("w_timeout", 32'd0, 32'd1);
                bus.WVALID = 1'b0;
                return;
            end
            tick();
            if (exp == RESP_OKAY) model_mem[idx + k] = d;
        end
        bus.WVALID = 1'b0;
        bus.WLAST  = 1'b0;
        cyc = 0;
        while (bus.BVALID !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        check("b_valid", 32'(bus.BVALID), 32'd1);
        for (int i = 0; i < bdelay; i++) begin
            bus.AWVALID = 1'b1;
            tick();
            check("b_hold_valid", 32'(bus.BVALID), 32'd1);
            check("b_hold_resp", 32'(bus.BRESP), 32'(exp));
            check("aw_blocked", 32'(bus.AWREADY), 32'd0);
        end
        bus.AWVALID = 1'b0;
        check("b_resp", 32'(bus.BRESP), 32'(exp));
        bus.BREADY = 1'b1;
        tick();
        bus.BREADY = 1'b0;
        check("b_done", 32'(bus.BVALID), 32'd0);
    endtask

    task automatic do_read(input logic [15:0] a, input logic [7:0] len, input logic [2:0] sz,
                           input bit stall, input logic [1:0] exp);
        int unsigned idx;
        int          k, cyc;
        bit          pstall;
        logic [31:0] pdata, expd;
        logic        plast;
        idx = 32'(a) / 4;
        bus.ARADDR  = a;
        bus.ARLEN   = len;
        bus.ARSIZE  = sz;
        bus.ARVALID = 1'b1;
        cyc = 0;
        while (bus.ARREADY !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        if (bus.ARREADY !== 1'b1) begin
            check("ar_timeout", 32'd0, 32'd1);
            bus.ARVALID = 1'b0;
            return;
        end
        tick();
        bus.ARVALID = 1'b0;
        k = 0; cyc = 0; pstall = 1'b0; pdata = '0; plast = 1'b0;
        while (k <= int'(len) && cyc < 5000) begin
            bus.RREADY = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (bus.RVALID === 1'b1) begin
                if (pstall) begin
                    check("r_hold_data", bus.RDATA, pdata);
                    check("r_hold_last", 32'(bus.RLAST), 32'(plast));
                end
                if (bus.RREADY) begin
                    expd = (exp == RESP_OKAY) ? model_mem[idx + k] : 32'd0;
                    check("r_data", bus.RDATA, expd);
                    check("r_resp", 32'(bus.RRESP), 32'(exp));
                    check("r_last", 32'(bus.RLAST), (k == int'(len)) ? 32'd1 : 32'd0);
                    k++;
                    pstall = 1'b0;
                end else begin
                    pstall = 1'b1;
                    pdata  = bus.RDATA;
                    plast  = bus.RLAST;
                end
            end
            tick();
            cyc++;
        end
        bus.RREADY = 1'b0;
        if (k <= int'(len)) check("r_timeout", 32'(k), 32'(len) + 32'd1);
        check("r_idle_valid", 32'(bus.RVALID), 32'd0);
        check("r_idle_last", 32'(bus.RLAST), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] a, ra;
        logic [7:0]  len, rlen;
        logic [2:0]  sz;
        logic [1:0]  exp, rexp;
        int          cyc;

        for (int i = 0; i < 1024; i++) model_mem[i] = 32'(i);
        bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWVALID = 1'b0;
        bus.WDATA  = '0; bus.WVALID = 1'b0; bus.WLAST = 1'b0; bus.BREADY = 1'b0;
        bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARVALID = 1'b0;
        bus.RREADY = 1'b0;

        vecs[0]  = '{1'b0, 16'h0010, 8'd3,   3'd2, RESP_OKAY};
        vecs[1]  = '{1'b1, 16'h0100, 8'd1,   3'd2, RESP_OKAY};
        vecs[2]  = '{1'b0, 16'h0100, 8'd1,   3'd2, RESP_OKAY};
        vecs[3]  = '{1'b1, 16'h0FF8, 8'd3,   3'd2, RESP_SLVERR};
        vecs[4]  = '{1'b0, 16'h0FFC, 8'd1,   3'd2, RESP_SLVERR};
        vecs[5]  = '{1'b0, 16'h0FF8, 8'd1,   3'd2, RESP_OKAY};
        vecs[6]  = '{1'b0, 16'h0FF8, 8'd2,   3'd2, RESP_SLVERR};
        vecs[7]  = '{1'b0, 16'h0000, 8'd255, 3'd0, RESP_OKAY};
        vecs[8]  = '{1'b0, 16'h0004, 8'd0,   3'd7, RESP_OKAY};
        vecs[9]  = '{1'b1, 16'h0F00, 8'd0,   3'd7, RESP_OKAY};
        vecs[10] = '{1'b0, 16'h0F80, 8'd0,   3'd7, RESP_OKAY};
        vecs[11] = '{1'b0, 16'h0F84, 8'd0,   3'd7, RESP_SLVERR};
        vecs[12] = '{1'b0, 16'h1000, 8'd0,   3'd0, RESP_SLVERR};
        vecs[13] = '{1'b1, 16'h0203, 8'd0,   3'd2, RESP_OKAY};
        vecs[14] = '{1'b0, 16'h0201, 8'd0,   3'd2, RESP_OKAY};
        vecs[15] = '{1'b1, 16'h2000, 8'd1,   3'd2, RESP_SLVERR};
        vecs[16] = '{1'b0, 16'h0F00, 8'd0,   3'd2, RESP_OKAY};
        vecs[17] = '{1'b0, 16'h0000, 8'd7,   3'd3, RESP_OKAY};
        vecs[18] = '{1'b0, 16'h0FC0, 8'd7,   3'd3, RESP_OKAY};
        vecs[19] = '{1'b0, 16'h0FC4, 8'd7,   3'd3, RESP_SLVERR};
        vecs[20] = '{1'b0, 16'h0000, 8'd255, 3'd7, RESP_SLVERR};

        // Reset state.
        #3 rst_n = 1'b0;
        tick();
        tick();
        check("rst_awready", 32'(bus.AWREADY), 32'd0);
        check("rst_arready", 32'(bus.ARREADY), 32'd0);
        check("rst_bvalid", 32'(bus.BVALID), 32'd0);
        check("rst_rvalid", 32'(bus.RVALID), 32'd0);
        check("rst_rdata", bus.RDATA, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_awready", 32'(bus.AWREADY), 32'd1);
        check("idle_arready", 32'(bus.ARREADY), 32'd1);

        // Directed table.
        wq.push_back(32'hDEADBEEF);
        wq.push_back(32'h12345678);
        for (int i = 0; i < 21; i++) begin
            if (vecs[i].wr) do_write(vecs[i].addr, vecs[i].len, vecs[i].size, 0, vecs[i].resp);
            else do_read(vecs[i].addr, vecs[i].len, vecs[i].size, (i % 2) == 1, vecs[i].resp);
        end

        // Write response backpressure: BREADY low for 5 cycles.
        do_write(16'h0300, 8'd2, 3'd2, 5, RESP_OKAY);
        do_read(16'h0300, 8'd2, 3'd2, 1'b1, RESP_OKAY);

        // Random bursts, some illegal, with random RREADY stalls.
        for (int i = 0; i < 30; i++) begin
            a   = 16'($urandom_range(0, 32'h10FF));
            len = 8'($urandom_range(0, 15));
            sz  = 3'($urandom_range(0, 3));
            exp = model_err(32'(a), 32'(len), 32'(sz)) ? RESP_SLVERR : RESP_OKAY;
            if ($urandom_range(0, 1) == 1) do_write(a, len, sz, 0, exp);
            else                           do_read(a, len, sz, 1'b1, exp);
        end

        // Simultaneous write and read on disjoint regions.
        for (int i = 0; i < 6; i++) begin
            a    = 16'(32'h0400 + 4 * $urandom_range(0, 100));
            ra   = 16'(32'h0800 + 4 * $urandom_range(0, 100));
            len  = 8'($urandom_range(0, 7));
            rlen = 8'($urandom_range(0, 7));
            exp  = model_err(32'(a), 32'(len), 32'd2) ? RESP_SLVERR : RESP_OKAY;
            rexp = model_err(32'(ra), 32'(rlen), 32'd2) ? RESP_SLVERR : RESP_OKAY;
            fork
                do_write(a, len, 3'd2, 0, exp);
                do_read(ra, rlen, 3'd2, 1'b1, rexp);
            join
        end
        do_read(16'h0400, 8'd127, 3'd2, 1'b0, RESP_OKAY);

        // Reset asserted in the middle of a 16-beat read.
        bus.ARADDR  = 16'h0000;
        bus.ARLEN   = 8'd15;
        bus.ARSIZE  = 3'd2;
        bus.ARVALID = 1'b1;
        cyc = 0;
        while (bus.ARREADY !== 1'b1 && cyc < 100) begin tick(); cyc++; end
        tick();
        bus.ARVALID = 1'b0;
        bus.RREADY  = 1'b1;
        tick();
        tick();
        tick();
        check("mid_rvalid", 32'(bus.RVALID), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_rvalid", 32'(bus.RVALID), 32'd0);
        check("abort_rlast", 32'(bus.RLAST), 32'd0);
        bus.RREADY = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_arready", 32'(bus.ARREADY), 32'd1);
        do_read(16'h0000, 8'd0, 3'd2, 1'b0, RESP_OKAY);
        // Words written before the reset survive it.
        do_read(16'h0100, 8'd1, 3'd2, 1'b0, RESP_OKAY);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
